// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: fetch request channel between the PC generator and
// instruction memory.
//   fetch_valid : fetch_pc carries a valid request
//   fetch_ready : instruction memory accepts the request this cycle
//   fetch_pc    : word-aligned fetch address
// Modports: master = PC generator, slave = instruction memory.
interface fetch_pc_unit_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_valid;
    logic              fetch_ready;
    logic [ADDR_W-1:0] fetch_pc;

    modport master (output fetch_valid, output fetch_pc, input fetch_ready);
    modport slave  (input fetch_valid, input fetch_pc, output fetch_ready);
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: registered fetch-stage program counter.
// Holds the fetch PC and offers it over a valid/ready handshake. It advances
// by 4 on each accepted request, or is redirected by resolved control flow
// (priority eret > exception > jr > jmp > taken branch). After a redirect,
// fetch_valid stays low for BUBBLES cycles.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fetch (master)      fetch_valid / fetch_ready / fetch_pc handshake
//   ctl_valid           qualifies all control inputs below
//   ctl_pc              PC of the resolving instruction
//   eret/epc            exception return and its target
//   exception/etarget   exception entry and its target
//   jr/ra               register jump and its target
//   jmp/target          absolute jump, word index within the ctl_pc region
//   branch/z/imm        branch, taken when z=0, signed word offset
//   redirect            one-cycle pulse: PC was redirected on the last edge
//   misalign            one-cycle pulse: misaligned eret/jr target trapped
// Optional feature: define FETCH_PC_ALIGN_CHECK_EN to trap a winning eret/jr
// target with nonzero low bits to EXC_VECTOR. Without it the low bits are
// cleared silently and misalign stays 0.
module fetch_pc_unit #(
    parameter int          ADDR_W     = 32,
    parameter int          TARGET_W   = 26,
    parameter int          IMM_W      = 16,
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter int          BUBBLES    = 1,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_pc_unit_if.master     fetch,
    input  logic                ctl_valid,
    input  logic [ADDR_W-1:0]   ctl_pc,
    input  logic                eret,
    input  logic [ADDR_W-1:0]   epc,
    input  logic                exception,
    input  logic [ADDR_W-1:0]   etarget,
    input  logic                jr,
    input  logic [ADDR_W-1:0]   ra,
    input  logic                jmp,
    input  logic [TARGET_W-1:0] target,
    input  logic                branch,
    input  logic                z,
    input  logic [IMM_W-1:0]    imm,
    output logic                redirect,
    output logic                misalign
);
    localparam logic [ADDR_W-1:0] MASK   = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC) & MASK;
    localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VECTOR) & MASK;
    localparam logic [2:0]        BUB    = 3'(BUBBLES);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] imm_ext, br_tgt, jmp_tgt, raw_tgt;
    logic              take_br, redir, mis_hit;
    logic              redirect_q, misalign_q;

    assign imm_ext = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign br_tgt  = ctl_pc + ADDR_W'(4) + (imm_ext << 2);
    assign jmp_tgt = {ctl_pc[ADDR_W-1:TARGET_W+2], target, 2'b00};
    assign take_br = branch & ~z;
    assign redir   = ctl_valid & (eret | exception | jr | jmp | take_br);

    // Priority mux; the branch target is the fall-through because a redirect
    // with none of the higher sources set can only be a taken branch.
    always_comb begin
        raw_tgt = br_tgt;
        if (eret)           raw_tgt = epc;
        else if (exception) raw_tgt = etarget;
        else if (jr)        raw_tgt = ra;
        else if (jmp)       raw_tgt = jmp_tgt;
    end

`ifdef FETCH_PC_ALIGN_CHECK_EN
    // Only eret/jr carry register-sourced targets that can be misaligned.
    assign mis_hit = redir & (eret | (~exception & jr)) & (raw_tgt[1:0] != 2'b00);
`else
    assign mis_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_nxt    = pc;
        if (redir) begin
            // A redirect wins over any stalled request and restarts the bubble count.
            pc_nxt = mis_hit ? EXC_PC : (raw_tgt & MASK);
            if (BUB != 3'd0) begin
                state_nxt = S_FLUSH;
                cnt_nxt   = BUB;
            end else begin
                state_nxt = S_RUN;
                cnt_nxt   = 3'd0;
            end
        end else begin
            case (state)
                S_BOOT:  state_nxt = S_RUN;
                S_RUN:   if (fetch.fetch_ready) pc_nxt = pc + ADDR_W'(4);
                S_FLUSH: begin
                    cnt_nxt = cnt - 3'd1;
                    if (cnt <= 3'd1) state_nxt = S_RUN;
                end
                default: state_nxt = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_BOOT;
            cnt        <= 3'd0;
            pc         <= RST_PC;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pc         <= pc_nxt;
            redirect_q <= redir;
            misalign_q <= mis_hit;
        end
    end

    assign fetch.fetch_valid = (state == S_RUN);
    assign fetch.fetch_pc    = pc;
    assign redirect          = redirect_q;
    assign misalign          = misalign_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scenarios followed by randomized control and
// ready traffic, compared each cycle against a behavioural PC model.
module tb_fetch_pc_unit;
    localparam int BUBBLES = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctl_valid = 1'b0, eret = 1'b0, exception = 1'b0, jr = 1'b0;
    logic        jmp = 1'b0, branch = 1'b0, z = 1'b0;
    logic [31:0] ctl_pc = '0, epc = '0, etarget = '0, ra = '0;
    logic [25:0] target = '0;
    logic [15:0] imm = '0;
    logic        redirect, misalign;

    fetch_pc_unit_if #(.ADDR_W(32)) fif ();

    fetch_pc_unit #(.BUBBLES(BUBBLES)) dut (
        .clk(clk), .rst_n(rst_n), .fetch(fif),
        .ctl_valid(ctl_valid), .ctl_pc(ctl_pc),
        .eret(eret), .epc(epc), .exception(exception), .etarget(etarget),
        .jr(jr), .ra(ra), .jmp(jmp), .target(target),
        .branch(branch), .z(z), .imm(imm),
        .redirect(redirect), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model: PC, cycles left before fetch_valid returns, expected pulses
    bit [31:0] m_pc;
    int        m_hold;
    bit        m_red, m_mis;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'hBFC0_0000;
        m_hold = 1;       // one boot cycle before the first request
        m_red  = 1'b0;
        m_mis  = 1'b0;
    endtask

    // One clock edge of the architectural behaviour, from the current inputs.
    task automatic model_step();
        bit [31:0] t;
        bit        chkd;
        longint    b;
        if (ctl_valid && (eret || exception || jr || jmp || (branch && !z))) begin
            chkd = 1'b0;
            if (eret)           begin t = epc; chkd = 1'b1; end
            else if (exception) t = etarget;
            else if (jr)        begin t = ra; chkd = 1'b1; end
            else if (jmp)       t = (ctl_pc & 32'hF000_0000) | (32'(target) * 4);
            else begin
                b = longint'(ctl_pc) + 4 + longint'($signed(imm)) * 4;
                t = 32'(b);
            end
            m_mis = 1'b0;
`ifdef FETCH_PC_ALIGN_CHECK_EN
            if (chkd && (t % 4 != 0)) begin
                t     = 32'hBFC0_0380;
                m_mis = 1'b1;
            end
`else
            chkd = chkd;
`endif
            m_pc   = t - (t % 4);
            m_hold = BUBBLES;
            m_red  = 1'b1;
        end else begin
            m_red = 1'b0;
            m_mis = 1'b0;
            if (m_hold > 0)               m_hold--;
            else if (fif.fetch_ready)     m_pc = m_pc + 4;
        end
    endtask

    task automatic compare_all();
        chk("valid",    fif.fetch_valid, (m_hold == 0));
        chk("pc",       fif.fetch_pc, m_pc);
        chk("redirect", redirect, m_red);
        chk("misalign", misalign, m_mis);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clr_ctl();
        ctl_valid = 0; eret = 0; exception = 0; jr = 0; jmp = 0; branch = 0; z = 0;
    endtask

    initial begin
        fif.fetch_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", fif.fetch_valid, 1'b0);
        chk("rst_pc", fif.fetch_pc, 32'hBFC0_0000);
        chk("rst_redirect", redirect, 1'b0);
        chk("rst_misalign", misalign, 1'b0);
        rst_n = 1'b1;

        // boot then sequential fetch
        cycle(); chk("seq0", fif.fetch_pc, 32'hBFC0_0000);
        cycle(); chk("seq1", fif.fetch_pc, 32'hBFC0_0004);
        cycle(); chk("seq2", fif.fetch_pc, 32'hBFC0_0008);

        // stall holds pc and valid
        fif.fetch_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("stall_pc", fif.fetch_pc, 32'hBFC0_0008);
            chk("stall_valid", fif.fetch_valid, 1'b1);
        end
        fif.fetch_ready = 1'b1;
        cycle(); chk("resume", fif.fetch_pc, 32'hBFC0_000C);

        // taken backward branch
        ctl_valid = 1; branch = 1; z = 0; ctl_pc = 32'h0040_0010; imm = 16'hFFFE;
        cycle();
        chk("br_pc", fif.fetch_pc, 32'h0040_000C);
        chk("br_redirect", redirect, 1'b1);
        chk("br_bubble", fif.fetch_valid, 1'b0);
        clr_ctl();
        cycle(); chk("br_redirect_end", redirect, 1'b0);
        chk("br_valid_back", fif.fetch_valid, 1'b1);
        // not-taken branch
        ctl_valid = 1; branch = 1; z = 1;
        cycle(); chk("nt_redirect", redirect, 1'b0);
        chk("nt_pc", fif.fetch_pc, 32'h0040_0010);
        clr_ctl();

        // priority: eret over exception and jr
        ctl_valid = 1; eret = 1; exception = 1; jr = 1;
        epc = 32'h8000_1000; etarget = 32'h1234_5670; ra = 32'h0BAD_0000;
        cycle(); chk("prio_pc", fif.fetch_pc, 32'h8000_1000);
        clr_ctl();
        cycle();

        // absolute jump
        ctl_valid = 1; jmp = 1; ctl_pc = 32'h9000_0000; target = 26'h0000100;
        cycle(); chk("jmp_pc", fif.fetch_pc, 32'h9000_0400);
        clr_ctl();
        cycle();

        // wrap at top of address space
        ctl_valid = 1; jr = 1; ra = 32'hFFFF_FFFC;
        cycle();
        clr_ctl();
        repeat (BUBBLES) cycle();
        chk("wrap_top", fif.fetch_pc, 32'hFFFF_FFFC);
        cycle(); chk("wrap_zero", fif.fetch_pc, 32'h0000_0000);

        // misaligned jr target
        ctl_valid = 1; jr = 1; ra = 32'h0040_0002;
        cycle();
`ifdef FETCH_PC_ALIGN_CHECK_EN
        chk("mis_pc", fif.fetch_pc, 32'hBFC0_0380);
        chk("mis_pulse", misalign, 1'b1);
`else
        chk("mis_pc", fif.fetch_pc, 32'h0040_0000);
        chk("mis_pulse", misalign, 1'b0);
`endif
        clr_ctl();
        cycle(); chk("mis_pulse_end", misalign, 1'b0);

        // reset in the middle of a flush
        ctl_valid = 1; jmp = 1; ctl_pc = 32'h1000_0000; target = 26'h0000040;
        cycle();
        clr_ctl();
        rst_n = 1'b0;
        #1;
        chk("midrst_pc", fif.fetch_pc, 32'hBFC0_0000);
        chk("midrst_valid", fif.fetch_valid, 1'b0);
        chk("midrst_redirect", redirect, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            fif.fetch_ready = ($urandom_range(0, 3) != 0);
            ctl_valid = ($urandom_range(0, 3) == 0);
            eret      = ($urandom_range(0, 7) == 0);
            exception = ($urandom_range(0, 7) == 0);
            jr        = ($urandom_range(0, 5) == 0);
            jmp       = ($urandom_range(0, 5) == 0);
            branch    = $urandom_range(0, 1);
            z         = $urandom_range(0, 1);
            ctl_pc    = $urandom;
            epc       = $urandom;
            etarget   = $urandom;
            ra        = $urandom;
            target    = 26'($urandom);
            imm       = 16'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
